// File: rtl/fir_coeff_loader_if.sv
// Coefficient load stream: valid/ready word handshake plus load-start request.
// The master drives words into the loader; the loader (slave) returns data_ready.
interface fir_coeff_loader_if #(
  parameter int unsigned SIZE = 8
);
  logic            load_start;
  logic [SIZE-1:0] data_in;
  logic            data_valid;
  logic            data_ready;

  modport master (
    output load_start,
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  load_start,
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Runtime coefficient loader for the FIR datapath.
// Words are collected into a shadow bank, then copied to the active bank in a
// single edge so the FIR never sees a partial set.
// Optional macro FIR_COEFF_CHECKSUM_EN: one trailing checksum word (sum of all
// words mod 2^SIZE) must match before the commit; a mismatch raises load_err.
module fir_coeff_loader #(
  parameter int unsigned NUM_COEFF = 4,
  parameter int unsigned SIZE      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fir_coeff_loader_if.slave         bus,
  output logic [NUM_COEFF*SIZE-1:0] coeffs,
  output logic                      coeffs_updated,
  output logic                      busy,
  output logic                      load_err
);

  localparam int unsigned     IW       = $clog2(NUM_COEFF) + 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_COEFF - 1);

`ifdef FIR_COEFF_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   index;
  logic [SIZE-1:0] shadow [NUM_COEFF];
  logic            word_accept;

  // A data word is taken only while collecting and not pre-empted by a restart.
  assign word_accept = (state == LOAD) && bus.data_valid && !bus.load_start;

`ifdef FIR_COEFF_CHECKSUM_EN
  logic [SIZE-1:0] sum;
  logic            check_accept;

  assign check_accept = (state == CHECK) && bus.data_valid && !bus.load_start;

  // Running checksum of the shadow bank, wrapping at SIZE bits.
  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < NUM_COEFF; k++) begin
      sum = sum + shadow[k];
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; load_start restarts from any state except COMMIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.load_start) state_next = LOAD;
      end
      LOAD: begin
        if (bus.load_start) begin
          state_next = LOAD;
        end else if (bus.data_valid && (index == LAST_IDX)) begin
`ifdef FIR_COEFF_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = COMMIT;
`endif
        end
      end
`ifdef FIR_COEFF_CHECKSUM_EN
      CHECK: begin
        if (bus.load_start) begin
          state_next = LOAD;
        end else if (bus.data_valid) begin
          state_next = (bus.data_in == sum) ? COMMIT : IDLE;
        end
      end
`endif
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    bus.data_ready = 1'b0;
    busy           = (state != IDLE);
    case (state)
      LOAD:    bus.data_ready = 1'b1;
`ifdef FIR_COEFF_CHECKSUM_EN
      CHECK:   bus.data_ready = 1'b1;
`endif
      default: bus.data_ready = 1'b0;
    endcase
  end

  // Shadow capture, index tracking and the atomic copy into the active bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index          <= '0;
      coeffs_updated <= 1'b0;
      for (int unsigned k = 0; k < NUM_COEFF; k++) begin
        shadow[k]                <= '0;
        coeffs[k*SIZE +: SIZE]   <= SIZE'(k + 1);
      end
    end else begin
      coeffs_updated <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int unsigned k = 0; k < NUM_COEFF; k++) begin
          coeffs[k*SIZE +: SIZE] <= shadow[k];
        end
      end else if (bus.load_start) begin
        index <= '0;
      end else if (word_accept) begin
        index <= index + IW'(1);
        for (int unsigned k = 0; k < NUM_COEFF; k++) begin
          if (index == IW'(k)) shadow[k] <= bus.data_in;
        end
      end
    end
  end

`ifdef FIR_COEFF_CHECKSUM_EN
  // Sticky checksum error; cleared only by a new load request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_err <= 1'b0;
    end else if (state != COMMIT && bus.load_start) begin
      load_err <= 1'b0;
    end else if (check_accept && (bus.data_in != sum)) begin
      load_err <= 1'b1;
    end
  end
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader (NUM_COEFF=4, SIZE=8).
// A queue-based model tracks collected words and the resulting coefficient set;
// it is compared against the DUT every cycle, plus literal spot checks.
module tb_fir_coeff_loader;

  localparam int unsigned NC = 4;
  localparam int unsigned SZ = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NC*SZ-1:0]   coeffs;
  logic               coeffs_updated;
  logic               busy;
  logic               load_err;

  fir_coeff_loader_if #(.SIZE(SZ)) bus ();

  fir_coeff_loader #(.NUM_COEFF(NC), .SIZE(SZ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .coeffs         (coeffs),
    .coeffs_updated (coeffs_updated),
    .busy           (busy),
    .load_err       (load_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [SZ-1:0]    mq [$];
  logic [NC*SZ-1:0] m_coeffs;
  logic             m_collect;
  logic             m_pending;
  logic             m_upd;
  logic             m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_coeffs  = 32'h04030201;
      m_collect = 1'b0;
      m_pending = 1'b0;
      m_upd     = 1'b0;
      m_err     = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (m_pending) begin
        for (int k = 0; k < NC; k++) m_coeffs[k*SZ +: SZ] = mq[k];
        m_pending = 1'b0;
        m_upd     = 1'b1;
      end else if (bus.load_start) begin
        mq.delete();
        m_collect = 1'b1;
        m_err     = 1'b0;
      end else if (m_collect && bus.data_valid) begin
        mq.push_back(bus.data_in);
`ifdef FIR_COEFF_CHECKSUM_EN
        if (mq.size() == NC + 1) begin
          logic [SZ-1:0] s;
          s = '0;
          for (int k = 0; k < NC; k++) s = s + mq[k];
          m_collect = 1'b0;
          if (s == mq[NC]) m_pending = 1'b1;
          else m_err = 1'b1;
        end
`else
        if (mq.size() == NC) begin
          m_collect = 1'b0;
          m_pending = 1'b1;
        end
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("coeffs",         coeffs,         m_coeffs);
    check("coeffs_updated", coeffs_updated, m_upd);
    check("busy",           busy,           m_collect || m_pending);
    check("data_ready",     bus.data_ready, m_collect);
    check("load_err",       load_err,       m_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic send(input logic [SZ-1:0] w, input int gap);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Full load; returns one ns after the edge that accepted the final word.
  task automatic load_set(input logic [SZ-1:0] w0, w1, w2, w3, input int gap,
                          input logic [SZ-1:0] ck_delta);
    pulse_start();
    send(w0, gap);
    send(w1, gap);
    send(w2, gap);
`ifdef FIR_COEFF_CHECKSUM_EN
    send(w3, gap);
    send(w0 + w1 + w2 + w3 + ck_delta, 0);
`else
    send(w3, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    step();
    step();
    check("reset_coeffs",     coeffs,         32'h04030201);
    check("reset_busy",       busy,           1'b0);
    check("reset_data_ready", bus.data_ready, 1'b0);
    check("reset_load_err",   load_err,       1'b0);
    #2 rst_n = 1'b1;
    step();

    // Back-to-back load.
    load_set(8'h10, 8'h20, 8'h30, 8'h40, 0, 8'h00);
    check("b2b_busy_commit",  busy,           1'b1);
    check("b2b_old_coeffs",   coeffs,         32'h04030201);
    step();
    check("b2b_coeffs",       coeffs,         32'h40302010);
    check("b2b_updated",      coeffs_updated, 1'b1);
    check("b2b_busy_low",     busy,           1'b0);
    step();
    check("b2b_updated_once", coeffs_updated, 1'b0);

    // Gapped valid; load_start during COMMIT must be ignored.
    load_set(8'h11, 8'h22, 8'h33, 8'h44, 1, 8'h00);
    check("gap_old_coeffs",   coeffs,         32'h40302010);
    pulse_start();
    check("gap_coeffs",       coeffs,         32'h44332211);
    check("gap_busy",         busy,           1'b0);
    step();
    check("gap_still_idle",   busy,           1'b0);

    // Restart mid-load with a colliding data word that must be dropped.
    pulse_start();
    send(8'h01, 0);
    send(8'h02, 0);
    bus.load_start = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hFF;
    step();
    bus.load_start = 1'b0;
    bus.data_valid = 1'b0;
    send(8'h05, 0);
    send(8'h06, 0);
    send(8'h07, 0);
`ifdef FIR_COEFF_CHECKSUM_EN
    send(8'h08, 0);
    send(8'h1A, 0);
`else
    send(8'h08, 0);
`endif
    step();
    check("restart_coeffs",   coeffs,         32'h08070605);
    step();

    // Reset in the middle of a load, then stray data in IDLE.
    pulse_start();
    send(8'h55, 0);
    send(8'h66, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_coeffs",    coeffs,         32'h04030201);
    check("midrst_busy",      busy,           1'b0);
    #1 rst_n = 1'b1;
    repeat (3) begin
      send(8'h99, 1);
    end
    check("idle_data_coeffs", coeffs,         32'h04030201);
    check("idle_data_busy",   busy,           1'b0);
    check("idle_data_upd",    coeffs_updated, 1'b0);
    check("idle_data_err",    load_err,       1'b0);

`ifdef FIR_COEFF_CHECKSUM_EN
    // Good checksum, then bad checksum with the previous set retained.
    load_set(8'h0A, 8'h0B, 8'h0C, 8'h0D, 0, 8'h00);
    step();
    check("ck_good_coeffs",   coeffs,         32'h0D0C0B0A);
    check("ck_good_err",      load_err,       1'b0);
    step();
    load_set(8'h01, 8'h02, 8'h03, 8'h04, 0, 8'h00);
    step();
    check("ck_ok_coeffs",     coeffs,         32'h04030201);
    step();
    load_set(8'h01, 8'h02, 8'h03, 8'h04, 0, 8'h01);
    check("ck_bad_err",       load_err,       1'b1);
    check("ck_bad_busy",      busy,           1'b0);
    step();
    check("ck_bad_coeffs",    coeffs,         32'h04030201);
    check("ck_bad_noupd",     coeffs_updated, 1'b0);
    check("ck_bad_sticky",    load_err,       1'b1);
    pulse_start();
    check("ck_err_cleared",   load_err,       1'b0);
    send(8'h01, 0);
    pulse_start();
    repeat (2) step();
`endif

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
